lz77_window_buf: RTL and testbench

- Parametrised LZ77 sliding-window byte buffer. Successor to the fixed 64x8 window RAM block.
- Circular RAM of DEPTH entries, split into a search window (bytes already coded) and a lookahead (bytes still to code).
- Adds a ready handshake on load, variable-length slide, an addressed read port for the match engine, occupancy count and flush.
- Sits between the input byte stream and the LZ77 match/encode engine.

---
 rtl/lz77_pkg.sv | 20 ++
 rtl/lz77_window_buf_if.sv | 49 ++++
 rtl/lz77_win_ram.sv | 36 +++
 rtl/lz77_window_buf.sv | 167 ++++++++++++++++
 tb/tb_lz77_window_buf.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lz77_pkg.sv
// Shared types and defaults for the LZ77 sliding-window buffer.
package lz77_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MATCH,
        ST_SLIDE
    } lz77_state_e;

    localparam int LZ_DATA_W     = 8;
    localparam int LZ_DEPTH      = 64;
    localparam int LZ_SEARCH_LEN = 48;

    // Counts must be able to hold DEPTH itself, hence one bit over log2.
    function automatic int lz_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lz77_window_buf_if.sv
// Handshake / data bus of the LZ77 window buffer.
// Optional second read port under LZ77_WIN_DUAL_RD_EN.
interface lz77_window_buf_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              i_clr;
    logic              i_ld;
    logic [DATA_W-1:0] i_data_in;
    logic              o_ld_ready;
    logic              i_start;
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_dout;
    logic              o_dout_valid;
    logic              i_sliding;
    logic [ADDR_W:0]   i_slide_len;
    logic [ADDR_W:0]   o_cursor;
    logic [ADDR_W:0]   o_count;
    logic              o_empty;
    logic              o_using;
    logic              o_full;
    logic              o_busy;
`ifdef LZ77_WIN_DUAL_RD_EN
    logic [ADDR_W-1:0] i_rd2_ofs;
    logic [DATA_W-1:0] o_dout2;
`endif

    modport master (
        output i_clr, i_ld, i_data_in, i_start, i_rd_en, i_rd_addr, i_sliding, i_slide_len,
`ifdef LZ77_WIN_DUAL_RD_EN
        output i_rd2_ofs,
        input  o_dout2,
`endif
        input  o_ld_ready, o_dout, o_dout_valid, o_cursor, o_count,
        input  o_empty, o_using, o_full, o_busy
    );

    modport slave (
        input  i_clr, i_ld, i_data_in, i_start, i_rd_en, i_rd_addr, i_sliding, i_slide_len,
`ifdef LZ77_WIN_DUAL_RD_EN
        input  i_rd2_ofs,
        output o_dout2,
`endif
        output o_ld_ready, o_dout, o_dout_valid, o_cursor, o_count,
        output o_empty, o_using, o_full, o_busy
    );

endinterface

// File: rtl/lz77_win_ram.sv
// Window RAM: one write port, one (or two with LZ77_WIN_DUAL_RD_EN)
// synchronous read ports with one cycle of latency. Contents are not reset.
module lz77_win_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
`ifdef LZ77_WIN_DUAL_RD_EN
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
`endif
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port(s)
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
`ifdef LZ77_WIN_DUAL_RD_EN
            o_rdata2 <= r_mem[i_raddr2];
`endif
        end
    end

endmodule

// File: rtl/lz77_window_buf.sv
// LZ77 sliding-window byte buffer: circular RAM split into search window
// [ws, ws+Cursor) and lookahead [ws+Cursor, ws+Count).
// Optional macro LZ77_WIN_DUAL_RD_EN adds a lookahead-relative read port.
module lz77_window_buf
    import lz77_pkg::*;
#(
    parameter int DATA_W     = LZ_DATA_W,
    parameter int DEPTH      = LZ_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SEARCH_LEN = LZ_SEARCH_LEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    lz77_window_buf_if.slave  bus
);
    localparam int CNT_W = lz_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_SLEN = CNT_W'(SEARCH_LEN);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

    lz77_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ws, r_wp, w_ws_nxt;
    logic [CNT_W-1:0]  r_cursor, r_count, r_slide_len, w_cursor_nxt, w_count_nxt;
    logic [CNT_W-1:0]  w_la, w_l, w_c, w_drop;
    logic              r_empty, r_using, r_full, r_dout_valid, r_rd_oor;
    logic              w_do_clr, w_do_wr, w_grab_len, w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_re = (r_state == ST_MATCH) && bus.i_rd_en;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle actions; IDLE priority Clr > Sliding > Ld > Start
    always_comb begin
        w_state_nxt = r_state;
        w_do_clr    = 1'b0;
        w_do_wr     = 1'b0;
        w_grab_len  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_clr) begin
                    w_do_clr = 1'b1;
                end else if (bus.i_sliding) begin
                    w_state_nxt = ST_SLIDE;
                    w_grab_len  = 1'b1;
                end else if (bus.i_ld) begin
                    w_state_nxt = ST_LOAD;
                    w_do_wr     = !r_full;
                end else if (bus.i_start) begin
                    w_state_nxt = ST_MATCH;
                end
            end
            ST_LOAD: begin
                if (!bus.i_ld) w_state_nxt = ST_IDLE;
                else           w_do_wr     = !r_full;
            end
            ST_MATCH: begin
                if (bus.i_sliding) begin
                    w_state_nxt = ST_SLIDE;
                    w_grab_len  = 1'b1;
                end else if (!bus.i_start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pointer updates: flush, load increment, or slide with search-window trim
    always_comb begin
        w_la         = r_count - r_cursor;
        w_l          = (r_slide_len < w_la) ? r_slide_len : w_la;
        w_c          = r_cursor + w_l;
        w_drop       = w_c - C_SLEN;
        w_ws_nxt     = r_ws;
        w_count_nxt  = r_count;
        w_cursor_nxt = r_cursor;
        if (w_do_clr) begin
            w_ws_nxt     = '0;
            w_count_nxt  = '0;
            w_cursor_nxt = '0;
        end else if (w_do_wr) begin
            w_count_nxt  = r_count + C_ONE;
        end else if (r_state == ST_SLIDE) begin
            if (w_c > C_SLEN) begin
                w_ws_nxt     = r_ws + w_drop[ADDR_W-1:0];
                w_count_nxt  = r_count - w_drop;
                w_cursor_nxt = C_SLEN;
            end else begin
                w_cursor_nxt = w_c;
            end
        end
    end

    // Pointer, status-flag and read-qualifier registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ws         <= '0;
            r_wp         <= '0;
            r_cursor     <= '0;
            r_count      <= '0;
            r_slide_len  <= '0;
            r_empty      <= 1'b1;
            r_using      <= 1'b0;
            r_full       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            r_ws         <= w_ws_nxt;
            r_count      <= w_count_nxt;
            r_cursor     <= w_cursor_nxt;
            if (w_do_clr)      r_wp <= '0;
            else if (w_do_wr)  r_wp <= r_wp + A_ONE;
            if (w_grab_len)    r_slide_len <= bus.i_slide_len;
            r_empty      <= (w_count_nxt == '0);
            r_full       <= (w_count_nxt == C_FULL);
            r_using      <= (w_count_nxt != '0) && (w_count_nxt != C_FULL);
            r_dout_valid <= w_re;
            if (w_re)          r_rd_oor <= ({1'b0, bus.i_rd_addr} >= r_count);
        end
    end

`ifdef LZ77_WIN_DUAL_RD_EN
    logic [DATA_W-1:0] w_rdata2;
    logic [CNT_W:0]    w_pos2;
    logic              r_rd2_oor;
    assign w_pos2 = {1'b0, r_cursor} + {2'b0, bus.i_rd2_ofs};

    // Out-of-range flag for the lookahead-relative port
    always_ff @(posedge i_clk) begin
        if (i_rst)     r_rd2_oor <= 1'b0;
        else if (w_re) r_rd2_oor <= (w_pos2 >= {1'b0, r_count});
    end

    assign bus.o_dout2 = (r_dout_valid && !r_rd2_oor) ? w_rdata2 : '0;
`endif

    lz77_win_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .i_clk    (i_clk),
        .i_we     (w_do_wr),
        .i_waddr  (r_wp),
        .i_wdata  (bus.i_data_in),
        .i_re     (w_re),
        .i_raddr  (r_ws + bus.i_rd_addr),
`ifdef LZ77_WIN_DUAL_RD_EN
        .i_raddr2 (r_ws + r_cursor[ADDR_W-1:0] + bus.i_rd2_ofs),
        .o_rdata2 (w_rdata2),
`endif
        .o_rdata  (w_rdata)
    );

    assign bus.o_ld_ready   = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !r_full;
    assign bus.o_dout       = (r_dout_valid && !r_rd_oor) ? w_rdata : '0;
    assign bus.o_dout_valid = r_dout_valid;
    assign bus.o_cursor     = r_cursor;
    assign bus.o_count      = r_count;
    assign bus.o_empty      = r_empty;
    assign bus.o_using      = r_using;
    assign bus.o_full       = r_full;
    assign bus.o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lz77_window_buf.sv
// Directed bench for lz77_window_buf with hand-computed expectations.
module tb_lz77_window_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lz77_window_buf_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    lz77_window_buf dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d);
        bus.i_ld      = 1'b1;
        bus.i_data_in = d;
        step();
    endtask

    task automatic ld_stop;
        bus.i_ld = 1'b0;
        step();
    endtask

    task automatic slide(input int n);
        bus.i_sliding   = 1'b1;
        bus.i_slide_len = 7'(n);
        step();
        bus.i_sliding   = 1'b0;
        chk("busy_slide", 32'(bus.o_busy), 32'd1);
        step();
    endtask

    task automatic match_on;
        bus.i_start = 1'b1;
        step();
    endtask

    task automatic match_off;
        bus.i_start = 1'b0;
        step();
    endtask

    task automatic rd(input string tag, input int a, input logic [7:0] exp);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = 6'(a);
        step();
        bus.i_rd_en   = 1'b0;
        chk({tag, "_dv"}, 32'(bus.o_dout_valid), 32'd1);
        chk(tag, 32'(bus.o_dout), 32'(exp));
    endtask

    task automatic chk_cc(input string tag, input int cnt, input int cur);
        chk({tag, "_count"},  32'(bus.o_count),  32'(cnt));
        chk({tag, "_cursor"}, 32'(bus.o_cursor), 32'(cur));
    endtask

    task automatic chk_idle_empty(input string tag);
        chk_cc(tag, 0, 0);
        chk({tag, "_empty"},    32'(bus.o_empty),    32'd1);
        chk({tag, "_busy"},     32'(bus.o_busy),     32'd0);
        chk({tag, "_ld_ready"}, 32'(bus.o_ld_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_clr = 0; bus.i_ld = 0; bus.i_data_in = '0; bus.i_start = 0;
        bus.i_rd_en = 0; bus.i_rd_addr = '0; bus.i_sliding = 0; bus.i_slide_len = '0;
`ifdef LZ77_WIN_DUAL_RD_EN
        bus.i_rd2_ofs = '0;
`endif
        step(); step();
        rst = 1'b0;

        // Reset state
        chk_idle_empty("rst");
        chk("rst_full",  32'(bus.o_full),       32'd0);
        chk("rst_using", 32'(bus.o_using),      32'd0);
        chk("rst_dout",  32'(bus.o_dout),       32'd0);
        chk("rst_dv",    32'(bus.o_dout_valid), 32'd0);

        // Load 0x00..0x09 over 10 cycles
        for (int i = 0; i < 10; i++) load_byte(8'(i));
        chk_cc("ld10", 10, 0);
        chk("ld10_using", 32'(bus.o_using), 32'd1);
        chk("ld10_empty", 32'(bus.o_empty), 32'd0);
        ld_stop();
        match_on();
        chk("match_ldrdy", 32'(bus.o_ld_ready), 32'd0);
        rd("rd3", 3, 8'h03);
        rd("rd10_oor", 10, 8'h00);
        match_off();
        chk("match_exit_busy", 32'(bus.o_busy), 32'd0);

        // Clamped slide: Cursor 8, Slide_len 5 -> only 2 lookahead bytes
        slide(8);
        chk_cc("sl8", 10, 8);
        slide(5);
        chk_cc("sl_clamp", 10, 10);
        slide(3);
        chk_cc("sl_noop", 10, 10);

        // Flush in IDLE
        bus.i_clr = 1'b1;
        step();
        bus.i_clr = 1'b0;
        chk_idle_empty("clr");

        // Fill to 64, then a held 65th byte must be dropped
        for (int i = 0; i < 64; i++) load_byte(8'(i));
        chk("fill_full", 32'(bus.o_full), 32'd1);
        load_byte(8'hEE);
        chk("full_count",  32'(bus.o_count),    32'd64);
        chk("full_ldrdy",  32'(bus.o_ld_ready), 32'd0);
        chk("full_using",  32'(bus.o_using),    32'd0);
        ld_stop();
        match_on();
        rd("rd0_noovw", 0, 8'h00);
        rd("rd63", 63, 8'h3F);
        match_off();

        // Slide trimming the search window: c=60, drop=12
        slide(40);
        chk_cc("sl40", 64, 40);
        slide(20);
        chk_cc("sl_trim", 52, 48);
        chk("sl_trim_full", 32'(bus.o_full), 32'd0);
        match_on();
        rd("rd0_ws12", 0, 8'h0C);
        rd("rd51", 51, 8'h3F);
        match_off();

        // Wrap: refill at wp=0.., slide 16 (ws=28), load 5 more
        for (int i = 0; i < 12; i++) load_byte(8'hC0 + 8'(i));
        ld_stop();
        chk_cc("wrap_ld12", 64, 48);
        slide(16);
        chk_cc("wrap_sl16", 48, 48);
        for (int i = 0; i < 5; i++) load_byte(8'hD0 + 8'(i));
        ld_stop();
        chk_cc("wrap_ld5", 53, 48);
        match_on();
        rd("wrap_last", 52, 8'hD4);
        rd("wrap_oor",  53, 8'h00);
        rd("wrap_la0",  48, 8'hD0);
`ifdef LZ77_WIN_DUAL_RD_EN
        bus.i_rd2_ofs = 6'd4;
        rd("dual_rd", 0, 8'h1C);
        chk("dual_dout2", 32'(bus.o_dout2), 32'hD4);
        bus.i_rd2_ofs = 6'd5;
        rd("dual_rd_b", 0, 8'h1C);
        chk("dual_oor", 32'(bus.o_dout2), 32'h00);
`endif
        match_off();

        // Reset mid-LOAD with Ld still asserted
        load_byte(8'hAA);
        load_byte(8'hBB);
        chk("midld_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_ld = 1'b0;
        chk_idle_empty("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
